// File: rtl/orb_match_packer.sv
`default_nettype none
// ============================================================================
// orb_match_packer : buffers 40-bit ORB match records, packs them into a 32-bit
// AXI4-Stream (two beats per match, TLAST trailer per frame).  Rev 1.0
// ============================================================================
module orb_match_packer #(
  parameter int FIFO_DEPTH         = 64,
  parameter int C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                          axi_Mclk,
  input  logic                          reset,
  input  logic                          match_valid,
  input  logic [39:0]                   match_data,
  input  logic                          frame_done,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_data,
  output logic                          m_axis_valid,
  input  logic                          m_axis_ready,
  output logic                          m_axis_last,
  output logic [3:0]                    m_axis_keep,
  output logic [15:0]                   frame_cnt,
  output logic                          overflow,
  output logic                          frame_intr
);

  localparam int          AW             = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_DEPTH        = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] C_MATCH_LIMIT  = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [22:0] C_MATCH_CNT_MAX = 23'h7FFFFF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BEAT0   = 2'd1,
    S_BEAT1   = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  logic [40:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr, r_occ;
  logic        r_eof_pending, r_drop_flag;
  logic [40:0] r_fetch;
  logic        r_fetched;
  logic [7:0]  r_rec_hi;
  logic [22:0] r_match_cnt;
  state_t      r_state, w_state_next;

  logic        w_hs, w_load, w_retire, w_fifo_empty, w_rd_en;
  logic        w_mark_wr, w_match_wr, w_drop, w_wr_en;
  logic [40:0] w_wr_data;

  assign w_hs       = m_axis_valid & m_axis_ready;
  assign w_mark_wr  = r_eof_pending & (r_occ < C_DEPTH);
  assign w_match_wr = match_valid & ~w_mark_wr & (r_occ < C_MATCH_LIMIT);
  assign w_drop     = match_valid & ~w_match_wr;
  assign w_wr_en    = w_mark_wr | w_match_wr;
  assign w_wr_data  = w_mark_wr ? {1'b1, 39'd0, r_drop_flag} : {1'b0, match_data};

  // Occupancy counts every record from write until its last beat retires, so
  // the prefetch and output stages share the FIFO_DEPTH budget.
  assign w_retire     = w_hs & ((r_state == S_BEAT1) | (r_state == S_TRAILER));
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_rd_en      = ~w_fifo_empty & (~r_fetched | w_load);

  always_ff @(posedge axi_Mclk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
  end

  always_ff @(posedge axi_Mclk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_occ         <= '0;
      r_eof_pending <= 1'b0;
      r_drop_flag   <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      case ({w_wr_en, w_retire})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      r_eof_pending <= (r_eof_pending & ~w_mark_wr) | frame_done;
      // A match dropped alongside the marker belongs to the next frame.
      r_drop_flag   <= w_mark_wr ? w_drop : (r_drop_flag | w_drop);
      if (w_drop || (frame_done && r_eof_pending && !w_mark_wr)) overflow <= 1'b1;
    end
  end

  always_ff @(posedge axi_Mclk or posedge reset) begin
    if (reset) begin
      r_rd_ptr  <= '0;
      r_fetch   <= '0;
      r_fetched <= 1'b0;
    end else if (w_rd_en) begin
      r_fetch   <= r_mem[r_rd_ptr[AW-1:0]];
      r_fetched <= 1'b1;
      r_rd_ptr  <= r_rd_ptr + 1'b1;
    end else if (w_load) begin
      r_fetched <= 1'b0;
    end
  end

  always_ff @(posedge axi_Mclk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_fetched) begin
          w_load       = 1'b1;
          w_state_next = r_fetch[40] ? S_TRAILER : S_BEAT0;
        end
      end
      S_BEAT0:            if (w_hs) w_state_next = S_BEAT1;
      S_BEAT1, S_TRAILER: if (w_hs) w_state_next = S_IDLE;
      default:            w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_Mclk or posedge reset) begin
    if (reset) begin
      m_axis_data  <= '0;
      m_axis_valid <= 1'b0;
      m_axis_last  <= 1'b0;
      m_axis_keep  <= 4'b0000;
      frame_cnt    <= 16'd0;
      frame_intr   <= 1'b0;
      r_rec_hi     <= 8'd0;
      r_match_cnt  <= 23'd0;
    end else begin
      frame_intr <= 1'b0;
      if (w_load) begin
        m_axis_valid <= 1'b1;
        m_axis_last  <= r_fetch[40];
        m_axis_keep  <= 4'b1111;
        r_rec_hi     <= r_fetch[39:32];
        m_axis_data  <= r_fetch[40] ? {8'h5A, r_fetch[0], r_match_cnt} : r_fetch[31:0];
      end else if (w_hs) begin
        if (r_state == S_BEAT0) begin
          m_axis_data <= {8'hA5, frame_cnt, r_rec_hi};
        end else begin
          m_axis_valid <= 1'b0;
          m_axis_last  <= 1'b0;
          m_axis_keep  <= 4'b0000;
          m_axis_data  <= '0;
        end
        if (r_state == S_BEAT1 && r_match_cnt != C_MATCH_CNT_MAX)
          r_match_cnt <= r_match_cnt + 1'b1;
        if (r_state == S_TRAILER) begin
          r_match_cnt <= 23'd0;
          frame_cnt   <= frame_cnt + 1'b1;
          frame_intr  <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/orb_match_packer.md
Name: orb_match_packer

Overview:
- Downstream stage of the ORB feature-matching wrapper: consumes the 40-bit match records it produces and packs them into a 32-bit AXI4-Stream for the S2MM DMA.
- Buffers matches in an internal FIFO. Each match is emitted as two beats; each frame is closed by a trailer beat with TLAST.
- Raises a one-cycle interrupt per completed frame so software can re-arm the DMA.

Parameters:
- FIFO_DEPTH, 64, number of 41-bit FIFO entries (power of two, >= 4)
- C_AXIS_TDATA_WIDTH, 32, stream data width (fixed at 32; parameter kept for port consistency)

Ports:
- axi_Mclk  input  1  single system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- match_valid  input  1  match_data holds a valid record this cycle
- match_data  input  40  match record, treated as opaque
- frame_done  input  1  one-cycle pulse: last match of the current frame has been presented
- m_axis_data  output  32  stream data
- m_axis_valid  output  1  stream valid
- m_axis_ready  input  1  stream ready
- m_axis_last  output  1  asserted on the trailer beat only
- m_axis_keep  output  4  constant 4'b1111 while valid, else 4'b0000
- frame_cnt  output  16  number of trailers transmitted, wraps at 16'hFFFF
- overflow  output  1  sticky: at least one match dropped since reset
- frame_intr  output  1  one-cycle pulse on the trailer handshake

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - All outputs are 0; FIFO is empty; FSM is in IDLE.
  - Per-frame counters and flags are cleared.
  - Reset mid-frame discards all buffered data. No partial frame is emitted.
- FIFO entry format, 41 bits:
  - Bit 40 = marker.
  - Match entry: marker=0, bits[39:0]=match_data.
  - Marker entry: marker=1, bit0=drop flag of that frame.
- Ingress:
  - At most one write per cycle.
  - A match is written if occupancy < FIFO_DEPTH-1. Otherwise it is dropped, the frame drop flag is set, and overflow is set. One slot is always reserved for the marker.
  - frame_done sets eof_pending.
  - A marker is written when eof_pending=1 and occupancy < FIFO_DEPTH. The marker has priority over a match arriving in the same cycle, and that match is dropped. Writing the marker clears eof_pending and the frame drop flag.
  - match_valid and frame_done in the same cycle: the match belongs to the closing frame and is written first; the marker is written on the next cycle.
  - frame_done while eof_pending is already 1: the pulses merge into one marker, and overflow is set.
- Egress FSM, states IDLE, BEAT0, BEAT1, TRAILER:
  - IDLE: if the FIFO is not empty, pop the head into a holding register. A match goes to BEAT0; a marker goes to TRAILER.
  - BEAT0: m_axis_data = record[31:0].
  - BEAT1: m_axis_data = {8'hA5, frame_cnt[15:0], record[39:32]}.
  - TRAILER: m_axis_data = {8'h5A, drop flag, match_cnt[22:0]}, m_axis_last=1.
  - Transitions: BEAT0 goes to BEAT1, BEAT1 goes to IDLE, TRAILER goes to IDLE. Each transition occurs only on the handshake (m_axis_valid & m_axis_ready).
  - Outputs are registered. Valid and data are held stable until the handshake; valid never drops without a handshake.
  - match_cnt counts matches emitted in the current frame, saturates at 23'h7FFFFF, and clears on the trailer handshake.
  - On the trailer handshake: frame_cnt increments and frame_intr pulses for one cycle.
  - One idle cycle in IDLE between records is permitted.
- Latency: with m_axis_ready held at 1, a match sampled at edge N into an empty FIFO gives m_axis_valid=1 after edge N+2, with its BEAT0 data.
- Empty frame: frame_done with no matches produces a trailer only, with count 0.

Test Plan:
- Single match 40'h12_3456_789A then frame_done, ready=1:
  - beats 32'h3456789A, 32'hA5000012, 32'h5A000001 (last=1);
  - frame_intr pulses once; frame_cnt becomes 1.
- frame_done alone → single beat 32'h5A000000 with last=1; frame_cnt increments.
- ready toggled 1-0-1 during a 3-match frame → no beat lost or duplicated; data and valid stable while ready=0; 7 beats total.
- FIFO_DEPTH=8, ready=0, 10 matches then frame_done, then ready=1:
  - 7 matches emitted; overflow=1;
  - trailer = 32'h5A800007.
- match_valid and frame_done in the same cycle → that match is counted in the closing frame's trailer; the next match lands in the following frame with the incremented frame_cnt in BEAT1.
- Assert reset during BEAT1 with ready=0 → outputs zero immediately; after release the FIFO is empty, frame_cnt=0, and there is no residual beat.
